// File: rtl/mode_sequencer.sv
// Demo mode sequencer: steps mode_num 0..4 on a debounced button press or an
// auto-step timer, refusing to advance past a stage whose done flag is low.
module mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_DELAY      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       auto_en,
    input  logic [3:0] stage_done,
    output logic [2:0] mode_num,
    output logic       step_ack,
    output logic       blocked,
    output logic       busy,
    output logic       seq_done
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int AUTO_W = (AUTO_DELAY > 1) ? $clog2(AUTO_DELAY) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DELAY - 1);

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                sync_meta_q, sync_meta_d;
    logic                sync_q, sync_d;
    logic                db_level_q, db_level_d;
    logic                db_prev_q, db_prev_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [AUTO_W-1:0]   auto_cnt_q, auto_cnt_d;
    logic                step_ack_q, step_ack_d;
    logic                blocked_q, blocked_d;

    logic cur_done;
    logic btn_req;
    logic auto_qual;
    logic auto_req;
    logic step_req;
    logic advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= M0;
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            db_level_q  <= 1'b0;
            db_prev_q   <= 1'b0;
            db_cnt_q    <= '0;
            auto_cnt_q  <= '0;
            step_ack_q  <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            db_level_q  <= db_level_d;
            db_prev_q   <= db_prev_d;
            db_cnt_q    <= db_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
            step_ack_q  <= step_ack_d;
            blocked_q   <= blocked_d;
        end
    end

    // Done flag of the stage currently running; mode 4 has no stage behind it.
    always_comb begin
        cur_done = 1'b0;
        case (state_q)
            M0:      cur_done = stage_done[0];
            M1:      cur_done = stage_done[1];
            M2:      cur_done = stage_done[2];
            M3:      cur_done = stage_done[3];
            default: cur_done = 1'b0;
        endcase
    end

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        sync_meta_d = btn_step;
        sync_d      = sync_meta_q;
        db_prev_d   = db_level_q;
        db_level_d  = db_level_q;
        db_cnt_d    = db_cnt_q;
        if (sync_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_level_d = sync_q;
            db_cnt_d   = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign btn_req   = db_level_q & ~db_prev_q;
    assign auto_qual = auto_en & cur_done;
    assign auto_req  = auto_qual & (auto_cnt_q == AUTO_LAST);
    assign step_req  = btn_req | auto_req;
    assign advance   = step_req & cur_done;

    always_comb begin
        auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        if (!auto_qual || auto_req || advance) begin
            auto_cnt_d = '0;
        end
    end

    // Requests that hit an unfinished stage are reported and dropped.
    always_comb begin
        state_d    = state_q;
        step_ack_d = 1'b0;
        blocked_d  = 1'b0;
        if (step_req && (state_q != M4)) begin
            if (cur_done) begin
                step_ack_d = 1'b1;
                case (state_q)
                    M0:      state_d = M1;
                    M1:      state_d = M2;
                    M2:      state_d = M3;
                    default: state_d = M4;
                endcase
            end else begin
                blocked_d = 1'b1;
            end
        end
    end

    assign mode_num = state_q;
    assign step_ack = step_ack_q;
    assign blocked  = blocked_q;
    assign seq_done = (state_q == M4);
    assign busy     = (state_q != M4) & ~cur_done;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: button, bounce, blocked, auto-step,
// coincident requests and asynchronous reset.
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_step = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] stage_done = 4'b0000;
    logic [2:0] mode_num;
    logic       step_ack;
    logic       blocked;
    logic       busy;
    logic       seq_done;

    int total = 0;
    int bad = 0;

    mode_sequencer #(.DEBOUNCE_CYCLES(4), .AUTO_DELAY(16)) dut (
        .clk(clk),
        .rst(rst),
        .btn_step(btn_step),
        .auto_en(auto_en),
        .stage_done(stage_done),
        .mode_num(mode_num),
        .step_ack(step_ack),
        .blocked(blocked),
        .busy(busy),
        .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic press_release();
        btn_step = 1'b1;
        tick(8);
        btn_step = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (mode_num !== 3'd0) begin bad++; $display("FAIL rst_mode got=%0d exp=0", mode_num); end
        total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0b exp=0", step_ack); end
        total++; if (blocked !== 1'b0) begin bad++; $display("FAIL rst_blocked got=%0b exp=0", blocked); end
        total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL rst_seq_done got=%0b exp=0", seq_done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        rst = 1'b0;
        $display("reset: mode=%0d ack=%0b blocked=%0b busy=%0b", mode_num, step_ack, blocked, busy);
    endtask

    task automatic test_button_step();
        int acks;
        stage_done = 4'b0001;
        btn_step = 1'b1;
        tick(6);
        total++; if (mode_num !== 3'd0 || step_ack !== 1'b0) begin bad++; $display("FAIL btn_early got=%0d/%0b exp=0/0", mode_num, step_ack); end
        tick(1);
        total++; if (mode_num !== 3'd1) begin bad++; $display("FAIL btn_mode got=%0d exp=1", mode_num); end
        total++; if (step_ack !== 1'b1) begin bad++; $display("FAIL btn_ack got=%0b exp=1", step_ack); end
        tick(1);
        total++; if (step_ack !== 1'b0) begin bad++; $display("FAIL btn_ack_clear got=%0b exp=0", step_ack); end
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (step_ack) acks++;
        end
        btn_step = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (step_ack) acks++;
        end
        total++; if (acks != 0 || mode_num !== 3'd1) begin bad++; $display("FAIL btn_hold got acks=%0d mode=%0d exp acks=0 mode=1", acks, mode_num); end
        $display("button step: mode=%0d extra_acks=%0d", mode_num, acks);
    endtask

    task automatic test_blocked();
        stage_done = 4'b0001;
        btn_step = 1'b1;
        tick(7);
        total++; if (blocked !== 1'b1 || step_ack !== 1'b0) begin bad++; $display("FAIL blk_pulse got=%0b/%0b exp=1/0", blocked, step_ack); end
        total++; if (mode_num !== 3'd1) begin bad++; $display("FAIL blk_mode got=%0d exp=1", mode_num); end
        tick(1);
        total++; if (blocked !== 1'b0) begin bad++; $display("FAIL blk_clear got=%0b exp=0", blocked); end
        btn_step = 1'b0;
        tick(8);
        stage_done = 4'b0011;
        btn_step = 1'b1;
        tick(7);
        total++; if (mode_num !== 3'd2 || step_ack !== 1'b1) begin bad++; $display("FAIL blk_retry got=%0d/%0b exp=2/1", mode_num, step_ack); end
        btn_step = 1'b0;
        tick(8);
        $display("blocked: mode=%0d", mode_num);
    endtask

    task automatic test_bounce();
        int acks;
        stage_done = 4'b0111;
        acks = 0;
        btn_step = 1'b1;
        tick(2);
        btn_step = 1'b0;
        tick(2);
        btn_step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (step_ack) acks++;
        end
        total++; if (acks != 0 || mode_num !== 3'd2) begin bad++; $display("FAIL bounce_early got acks=%0d mode=%0d exp 0/2", acks, mode_num); end
        tick(1);
        total++; if (mode_num !== 3'd3 || step_ack !== 1'b1) begin bad++; $display("FAIL bounce_step got=%0d/%0b exp=3/1", mode_num, step_ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_m3 got=%0b exp=1", busy); end
        stage_done = 4'b1000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_m3_done got=%0b exp=0", busy); end
        btn_step = 1'b0;
        tick(8);
        $display("bounce: mode=%0d", mode_num);
    endtask

    task automatic test_auto();
        int acks;
        do_reset();
        auto_en = 1'b1;
        stage_done = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                tick(8);
                auto_en = 1'b0;
                tick(1);
                auto_en = 1'b1;
            end
            tick(15);
            total++; if (mode_num !== 3'(k)) begin bad++; $display("FAIL auto_hold%0d got=%0d exp=%0d", k, mode_num, k); end
            tick(1);
            total++; if (mode_num !== 3'(k + 1) || step_ack !== 1'b1) begin bad++; $display("FAIL auto_step%0d got=%0d/%0b exp=%0d/1", k, mode_num, step_ack, k + 1); end
            $display("auto: mode=%0d", mode_num);
        end
        total++; if (seq_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL auto_done got=%0b/%0b exp=1/0", seq_done, busy); end
        acks = 0;
        btn_step = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (step_ack || blocked) acks++;
        end
        btn_step = 1'b0;
        tick(8);
        total++; if (acks != 0 || mode_num !== 3'd4) begin bad++; $display("FAIL auto_m4 got pulses=%0d mode=%0d exp 0/4", acks, mode_num); end
        auto_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acks;
        do_reset();
        auto_en = 1'b0;
        stage_done = 4'b1111;
        press_release();
        press_release();
        total++; if (mode_num !== 3'd2) begin bad++; $display("FAIL b2b_setup got=%0d exp=2", mode_num); end
        acks = 0;
        auto_en = 1'b1;
        tick(9);
        btn_step = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (step_ack) acks++;
        end
        total++; if (acks != 1 || mode_num !== 3'd3) begin bad++; $display("FAIL b2b_single got acks=%0d mode=%0d exp 1/3", acks, mode_num); end
        tick(1);
        total++; if (step_ack !== 1'b0 || mode_num !== 3'd3) begin bad++; $display("FAIL b2b_after got=%0b/%0d exp=0/3", step_ack, mode_num); end
        $display("back to back: mode=%0d acks=%0d", mode_num, acks);
        #2 rst = 1'b1;
        #1;
        total++; if (mode_num !== 3'd0 || step_ack !== 1'b0 || seq_done !== 1'b0) begin bad++; $display("FAIL async_rst got=%0d/%0b/%0b exp=0/0/0", mode_num, step_ack, seq_done); end
        auto_en = 1'b0;
        stage_done = 4'b0001;
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        total++; if (mode_num !== 3'd0) begin bad++; $display("FAIL held_early got=%0d exp=0", mode_num); end
        tick(1);
        total++; if (mode_num !== 3'd1 || step_ack !== 1'b1) begin bad++; $display("FAIL held_step got=%0d/%0b exp=1/1", mode_num, step_ack); end
        btn_step = 1'b0;
        tick(8);
        $display("async reset: mode=%0d", mode_num);
    endtask

    initial begin
        test_reset();
        test_button_step();
        test_blocked();
        test_bounce();
        test_auto();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Produces the 3-bit mode_num consumed by the top-level stage controller.
- Steps the demo through modes 0→1→2→3→4: memory load, single PE, 3x3 systolic array, 2x2 systolic array, display.
- Advances on a debounced push-button step or an optional auto-step timer.
- Each advance is gated by the done flag of the stage currently running, so the controller never moves past an unfinished stage.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable clock samples needed to accept a button level change (board builds override, e.g. 500000).
- AUTO_DELAY, 16: consecutive cycles the current stage's done flag must be high, with auto_en=1, before an automatic step.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- btn_step  in  1  raw asynchronous push-button, active-high
- auto_en  in  1  enables automatic stepping
- stage_done  in  4  done flags: [0] memory loaded, [1] single PE done, [2] SA3x3 done, [3] SA2x2 done
- mode_num  out  3  current mode 0..4, registered
- step_ack  out  1  one-cycle pulse: mode_num advanced this cycle
- blocked  out  1  one-cycle pulse: step requested while current stage not done
- busy  out  1  mode_num<4 and stage_done[mode_num]=0
- seq_done  out  1  mode_num==4

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - On reset: mode_num=0, step_ack=0, blocked=0, seq_done=0; synchronizer flops, debounced level, debounce counter and auto counter all 0.
  - busy follows its combinational definition (1 if stage_done[0]=0).
- Synchronizer: 2-flop chain on btn_step; its output is sync_q.
- Debounce, at each clk edge:
  - If sync_q == db_level: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: db_level <= sync_q and db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - A level is accepted on the DEBOUNCE_CYCLES-th consecutive differing edge. Any glitch back to db_level restarts the count.
- Button request: btn_req = db_level & ~db_level_q, combinational, high for one cycle per accepted press. Release generates nothing.
- Auto request:
  - A cycle qualifies when auto_en=1, mode_num<4 and stage_done[mode_num]=1.
  - auto_cnt increments on qualifying cycles and clears on any non-qualifying cycle.
  - auto_req = qualifying & (auto_cnt == AUTO_DELAY-1); auto_cnt clears on that cycle.
- step_req = btn_req | auto_req. A simultaneous button and auto request is one request and gives one advance.
- FSM states M0..M4, with the state equal to mode_num. On a clock edge where step_req=1:
  - Mk, k<4, stage_done[k]=1: go to Mk+1 and register step_ack=1. Auto counter clears.
  - Mk, k<4, stage_done[k]=0: stay in Mk and register blocked=1. The request is dropped, not queued.
  - M4: ignored. No pulse; the state stays M4 until reset.
- step_ack and blocked are registered, high for exactly one cycle, and never high together.
- Latency:
  - Button: raw edge → 2 sync edges → DEBOUNCE_CYCLES edges to db_level → mode_num changes on the next edge.
  - Auto: mode_num changes on the edge after the AUTO_DELAY-th consecutive qualifying cycle.
- mode_num increments by exactly 1 per advance and never exceeds 4; there is no wrap-around.
- Reset mid-operation returns to M0 immediately.
  - If btn_step is still held when reset is released, it is debounced afresh and produces one request after 2+DEBOUNCE_CYCLES edges.
  - That request advances M0 only if stage_done[0]=1.
- A stage_done bit for a stage other than the current one has no effect.

Test Plan:
- Reset with btn_step=0 → mode_num=0, step_ack=0, blocked=0, seq_done=0, busy=1 with stage_done=0000.
- stage_done=0001, btn_step rises before edge 0 and is held (DEBOUNCE_CYCLES=4) → db_level=1 after edge 5, mode_num=1 and step_ack=1 after edge 6, step_ack=0 after edge 7. Holding longer gives no further step.
- Button bounce: btn_step toggles 1,0,1 with 2-cycle gaps, then stays high → exactly one advance, only after 4 stable sync_q samples.
- Mode 1, stage_done=0001, press → blocked pulses for 1 cycle, mode_num stays 1. Then set stage_done=0011 and press → mode_num=2.
- auto_en=1, stage_done=1111 from M0, AUTO_DELAY=16 → mode_num steps 0,1,2,3,4 at 16-cycle intervals. seq_done=1 at 4, after which no more step_ack. Dropping auto_en for 1 cycle mid-count restarts the 16-cycle count.
- Button accept coincides with an auto request in M2 → mode_num=3 with a single step_ack. Assert rst during M3 → mode_num=0 asynchronously, counters cleared.
